// File: rtl/serial_tc_engine_pkg.sv
// Shared types and helpers for the bit-serial two's-complement negation engine.
package serial_tc_pkg;

   typedef enum logic {
      MODE_PASS = 1'b0,
      MODE_NEG  = 1'b1
   } mode_e;

   localparam int unsigned WORD_W_MAX = 32;
   localparam int unsigned LANES_MAX  = 8;

   // Packages cannot take parameters: this is the widest legal lane word.
   // Modules declare their own lane_word_t at their WORD_W.
   typedef logic [WORD_W_MAX-1:0] lane_word_max_t;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned res;
      res = 0;
      for (int unsigned p = 1; p < v; p = p << 1) begin
         res = res + 1;
      end
      return res;
   endfunction

endpackage

// File: rtl/serial_tc_engine_if.sv
// Serial stream in, serial and parallel results out, for serial_tc_engine.
interface serial_tc_engine_if #(
   parameter int unsigned WORD_W = 8,
   parameter int unsigned LANES  = 1
);
   logic                    in_valid;
   logic [LANES-1:0]        in_bit;
   logic [LANES-1:0]        neg_en;
   logic                    out_valid;
   logic [LANES-1:0]        out_bit;
   logic                    word_done;
   logic [LANES*WORD_W-1:0] out_word;
   logic [LANES-1:0]        ovf;

   modport master (
      output in_valid, in_bit, neg_en,
      input  out_valid, out_bit, word_done, out_word, ovf
   );

   modport slave (
      input  in_valid, in_bit, neg_en,
      output out_valid, out_bit, word_done, out_word, ovf
   );
endinterface

// File: rtl/serial_tc_engine_lane.sv
// One serial lane: mode latch, seen-one tracking, result shift register, overflow.
// SERIAL_TC_SAT_EN: saturate the parallel word of an overflowing lane.
module serial_tc_lane
   import serial_tc_pkg::*;
#(
   parameter int unsigned WORD_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              acc_i,
   input  logic              start_i,
   input  logic              end_i,
   input  logic              bit_i,
   input  logic              neg_en_i,
   output logic              out_bit_o,
   output logic [WORD_W-1:0] word_o,
   output logic              ovf_o
);

   typedef logic [WORD_W-1:0] lane_word_t;

   mode_e      mode_q, mode_d, mode_eff;
   logic       seen_q, seen_d, seen_eff;
   lane_word_t shreg_q, shreg_d;
   lane_word_t word_q, word_d;
   logic       out_bit_q, out_bit_d;
   logic       ovf_q, ovf_d;
   logic       y;
   logic       ovf_hit;

   always_comb begin
      // On a word's first bit the fresh neg_en and a cleared seen flag apply immediately.
      mode_eff  = start_i ? mode_e'(neg_en_i) : mode_q;
      seen_eff  = start_i ? 1'b0 : seen_q;
      y         = (mode_eff == MODE_NEG && seen_eff) ? ~bit_i : bit_i;
      ovf_hit   = (mode_eff == MODE_NEG) && !seen_eff && bit_i;

      mode_d    = mode_q;
      seen_d    = seen_q;
      shreg_d   = shreg_q;
      word_d    = word_q;
      out_bit_d = out_bit_q;
      ovf_d     = ovf_q;

      if (acc_i) begin
         mode_d    = mode_eff;
         seen_d    = seen_eff | bit_i;
         shreg_d   = {y, shreg_q[WORD_W-1:1]};
         out_bit_d = y;
         if (end_i) begin
            ovf_d = ovf_hit;
`ifdef SERIAL_TC_SAT_EN
            word_d = ovf_hit ? {1'b0, {(WORD_W-1){1'b1}}} : shreg_d;
`else
            word_d = shreg_d;
`endif
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mode_q    <= MODE_PASS;
         seen_q    <= 1'b0;
         shreg_q   <= '0;
         word_q    <= '0;
         out_bit_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         mode_q    <= mode_d;
         seen_q    <= seen_d;
         shreg_q   <= shreg_d;
         word_q    <= word_d;
         out_bit_q <= out_bit_d;
         ovf_q     <= ovf_d;
      end
   end

   assign out_bit_o = out_bit_q;
   assign word_o    = word_q;
   assign ovf_o     = ovf_q;

endmodule

// File: rtl/serial_tc_engine.sv
// Bit-serial two's-complement negation over LANES lanes sharing one framing counter.
// SERIAL_TC_SAT_EN (in serial_tc_lane) saturates overflowing parallel words.
module serial_tc_engine
   import serial_tc_pkg::*;
#(
   parameter int unsigned WORD_W = 8,
   parameter int unsigned LANES  = 1
) (
   input logic               t_clk,
   input logic               r,
   serial_tc_engine_if.slave bus
);

   localparam int unsigned CNT_W = clog2(WORD_W);

   logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
   logic                    out_valid_q, out_valid_d;
   logic                    word_done_q, word_done_d;
   logic                    cnt_first, cnt_last;
   logic [LANES-1:0]        lane_bit;
   logic [LANES-1:0]        lane_ovf;
   logic [LANES*WORD_W-1:0] lane_word;

   assign cnt_first = (bit_cnt_q == '0);
   assign cnt_last  = (bit_cnt_q == CNT_W'(WORD_W - 1));

   always_comb begin
      bit_cnt_d   = bit_cnt_q;
      out_valid_d = bus.in_valid;
      word_done_d = bus.in_valid && cnt_last;
      if (bus.in_valid) begin
         bit_cnt_d = cnt_last ? '0 : bit_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge t_clk) begin
      if (r) begin
         bit_cnt_q   <= '0;
         out_valid_q <= 1'b0;
         word_done_q <= 1'b0;
      end else begin
         bit_cnt_q   <= bit_cnt_d;
         out_valid_q <= out_valid_d;
         word_done_q <= word_done_d;
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      serial_tc_lane #(.WORD_W(WORD_W)) u_lane (
         .clk_i    (t_clk),
         .rst_i    (r),
         .acc_i    (bus.in_valid),
         .start_i  (cnt_first),
         .end_i    (cnt_last),
         .bit_i    (bus.in_bit[k]),
         .neg_en_i (bus.neg_en[k]),
         .out_bit_o(lane_bit[k]),
         .word_o   (lane_word[k*WORD_W +: WORD_W]),
         .ovf_o    (lane_ovf[k])
      );
   end

   assign bus.out_valid = out_valid_q;
   assign bus.word_done = word_done_q;
   assign bus.out_bit   = lane_bit;
   assign bus.out_word  = lane_word;
   assign bus.ovf       = lane_ovf;

endmodule

// File: tb/tb_serial_tc_engine.sv
// Directed-vector bench for serial_tc_engine, WORD_W=8, LANES=2.
module tb_serial_tc_engine;
   import serial_tc_pkg::*;

   localparam int unsigned W = 8;
   localparam int unsigned L = 2;

`ifdef SERIAL_TC_SAT_EN
   localparam logic [7:0] OVW = 8'h7F;
`else
   localparam logic [7:0] OVW = 8'h80;
`endif

   logic t_clk = 1'b0;
   logic r;
   always #5 t_clk = ~t_clk;

   serial_tc_engine_if #(.WORD_W(W), .LANES(L)) bus ();
   serial_tc_engine #(.WORD_W(W), .LANES(L)) dut (
      .t_clk(t_clk),
      .r    (r),
      .bus  (bus)
   );

   typedef struct {
      logic [1:0] neg;
      logic [7:0] in0, in1;
      logic [7:0] ser0, ser1;
      logic [7:0] wrd0, wrd1;
      logic [1:0] ovf;
      bit         stall;
   } vec_t;

   vec_t vecs[7];
   vec_t rv;
   int   checks = 0;
   int   errors = 0;
   logic [15:0] prev;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge t_clk);
      #1;
   endtask

   // neg_en is inverted on every bit but the first to show it is ignored mid-word.
   task automatic send_vec(input vec_t v, input logic [15:0] prev_word);
      for (int i = 0; i < 8; i++) begin
         bus.in_valid = 1'b1;
         bus.in_bit   = {v.in1[i], v.in0[i]};
         bus.neg_en   = (i == 0) ? v.neg : ~v.neg;
         tick();
         chk("out_valid", 32'(bus.out_valid), 32'd1);
         chk("out_bit", 32'(bus.out_bit), 32'({v.ser1[i], v.ser0[i]}));
         chk("word_done", 32'(bus.word_done), 32'(i == 7));
         if (i < 7) begin
            chk("out_word_hold", 32'(bus.out_word), 32'(prev_word));
         end else begin
            chk("out_word", 32'(bus.out_word), 32'({v.wrd1, v.wrd0}));
            chk("ovf", 32'(bus.ovf), 32'(v.ovf));
         end
         if (v.stall && i < 7) begin
            bus.in_valid = 1'b0;
            bus.in_bit   = ~bus.in_bit;
            bus.neg_en   = ~bus.neg_en;
            tick();
            chk("stall_valid", 32'(bus.out_valid), 32'd0);
            chk("stall_done", 32'(bus.word_done), 32'd0);
            tick();
            chk("stall_valid2", 32'(bus.out_valid), 32'd0);
         end
      end
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_valid"}, 32'(bus.out_valid), 32'd0);
      chk({nm, "_bit"}, 32'(bus.out_bit), 32'd0);
      chk({nm, "_done"}, 32'(bus.word_done), 32'd0);
      chk({nm, "_word"}, 32'(bus.out_word), 32'd0);
      chk({nm, "_ovf"}, 32'(bus.ovf), 32'd0);
   endtask

   initial begin
      r            = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_bit   = '0;
      bus.neg_en   = '0;
      tick();
      tick();
      chk_zero("reset");
      r = 1'b0;

      vecs[0] = '{neg:2'b01, in0:8'h0A, in1:8'h00, ser0:8'hF6, ser1:8'h00,
                  wrd0:8'hF6, wrd1:8'h00, ovf:2'b00, stall:1'b0};
      vecs[1] = '{neg:2'b01, in0:8'h80, in1:8'h80, ser0:8'h80, ser1:8'h80,
                  wrd0:OVW,   wrd1:8'h80, ovf:2'b01, stall:1'b0};
      vecs[2] = '{neg:2'b01, in0:8'h01, in1:8'h3C, ser0:8'hFF, ser1:8'h3C,
                  wrd0:8'hFF, wrd1:8'h3C, ovf:2'b00, stall:1'b0};
      vecs[3] = '{neg:2'b11, in0:8'h00, in1:8'h00, ser0:8'h00, ser1:8'h00,
                  wrd0:8'h00, wrd1:8'h00, ovf:2'b00, stall:1'b0};
      vecs[4] = '{neg:2'b10, in0:8'h80, in1:8'h7F, ser0:8'h80, ser1:8'h81,
                  wrd0:8'h80, wrd1:8'h81, ovf:2'b00, stall:1'b0};
      vecs[5] = '{neg:2'b11, in0:8'hFF, in1:8'h80, ser0:8'h01, ser1:8'h80,
                  wrd0:8'h01, wrd1:OVW,   ovf:2'b10, stall:1'b0};
      vecs[6] = '{neg:2'b11, in0:8'h05, in1:8'h02, ser0:8'hFB, ser1:8'hFE,
                  wrd0:8'hFB, wrd1:8'hFE, ovf:2'b00, stall:1'b1};

      prev = 16'h0000;
      for (int v = 0; v < 7; v++) begin
         send_vec(vecs[v], prev);
         prev = {vecs[v].wrd1, vecs[v].wrd0};
      end

      // Abort a word after four bits; the reset cycle also carries a valid bit.
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_bit   = '1;
         bus.neg_en   = '1;
         tick();
         chk("abort_valid", 32'(bus.out_valid), 32'd1);
         chk("abort_done", 32'(bus.word_done), 32'd0);
      end
      r            = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_bit   = '1;
      tick();
      chk_zero("midreset");
      r = 1'b0;

      rv = '{neg:2'b01, in0:8'h02, in1:8'h00, ser0:8'hFE, ser1:8'h00,
             wrd0:8'hFE, wrd1:8'h00, ovf:2'b00, stall:1'b0};
      send_vec(rv, 16'h0000);

      bus.in_valid = 1'b0;
      tick();
      chk("idle_valid", 32'(bus.out_valid), 32'd0);
      chk("idle_word_hold", 32'(bus.out_word), 32'h00FE);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
